vga_pll_ctrl: RTL
=================

Name: vga_pll_ctrl

Overview:
- Sequences the 50 MHz -> 108 MHz VGA PLL (1280x1024@60 pixel clock).
- Pulses the PLL reset, waits for lock with a timeout, and qualifies the lock as stable.
- Releases the VGA-domain reset request, detects loss of lock, and retries or declares failure.
- Runs entirely on the 50 MHz reference clock, because the PLL output is not trustworthy before lock.

Parameters:
- RST_HOLD_CYC, 16, cycles pll_rst is held high per PLL reset pulse (min 1).
- LOCK_TIMEOUT_CYC, 50000, max cycles in WAIT_LOCK before a retry (1 ms at 50 MHz).
- LOCK_STABLE_CYC, 1024, consecutive synchronized-lock cycles required before RUN.
- MAX_RETRIES, 3, timeouts allowed after the first attempt before FAIL.
- CNT_W, 16, width of the shared down/up cycle counter; must hold the largest of the three cycle parameters.

Ports:
- refclk  in  1  50 MHz reference clock; same net that feeds the PLL.
- rst_n  in  1  asynchronous, active-low reset.
- pll_locked  in  1  PLL lock output; asynchronous to refclk.
- ctrl_restart  in  1  single-cycle request to re-run the full lock sequence.
- pll_rst  out  1  active-high reset to the PLL.
- vga_rst_req  out  1  active-high reset request to the 108 MHz domain; the receiving domain synchronizes it.
- pll_ok  out  1  high only in RUN.
- pll_fail  out  1  high only in FAIL.
- state_o  out  3  encoded state: RESET_PLL=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, FAIL=4.
- retry_cnt  out  2  timeouts in the current sequence.
- lock_loss_cnt  out  8  count of RUN->lock-loss events; saturates at 255.

Behaviour:
- Reset values (rst_n low):
  - state RESET_PLL, pll_rst=1, vga_rst_req=1, pll_ok=0, pll_fail=0.
  - retry_cnt=0, lock_loss_cnt=0, counter=0, both synchronizer flops=0.
- All outputs are registered. Decoded outputs change on the cycle the state changes.
- pll_locked passes through a 2-flop synchronizer (lock_s). Latency from a pll_locked edge to an FSM reaction is 2 refclk cycles, plus one cycle for the state register.
- RESET_PLL:
  - pll_rst=1, vga_rst_req=1. Counter counts 0..RST_HOLD_CYC-1.
  - On the last count -> WAIT_LOCK, counter cleared. pll_rst is high for exactly RST_HOLD_CYC cycles.
- WAIT_LOCK:
  - pll_rst=0. Counter increments.
  - lock_s=1 -> STABILIZE, counter cleared.
  - Else if counter = LOCK_TIMEOUT_CYC-1:
    - if retry_cnt < MAX_RETRIES: retry_cnt++, -> RESET_PLL.
    - otherwise -> FAIL.
  - If lock and timeout occur in the same cycle, lock wins.
- STABILIZE:
  - Counter increments while lock_s=1.
  - lock_s=0 -> WAIT_LOCK with counter cleared; retry_cnt unchanged (the timeout restarts).
  - Counter = LOCK_STABLE_CYC-1 with lock_s=1 -> RUN, retry_cnt cleared.
- RUN:
  - vga_rst_req=0, pll_ok=1.
  - lock_s=0 -> lock_loss_cnt++ (saturating), -> RESET_PLL, retry_cnt=0.
- FAIL:
  - pll_rst=1, vga_rst_req=1, pll_fail=1.
  - Leaves only via ctrl_restart or rst_n.
- ctrl_restart:
  - Valid in any state, highest priority: -> RESET_PLL next cycle, counter and retry_cnt cleared.
  - If it coincides with a RUN lock loss, lock_loss_cnt still increments.
  - If it arrives while already in RESET_PLL, the hold period restarts.
- vga_rst_req is 0 only in RUN. It reasserts in the cycle RUN is exited.
- Asserting rst_n mid-sequence returns every register to its reset value immediately (asynchronous). Deassertion is expected to be synchronous to refclk externally.

Decomposition:
- Shared package vga_pkg holds:
  - the state enum (state encodings above);
  - the default timing constants (PLL_RST_HOLD, PLL_LOCK_TIMEOUT, PLL_LOCK_STABLE);
  - the VGA_PIX_HZ = 108_000_000 constant.
- One sub-module, sync_2ff: generic 2-flop synchronizer with async active-low reset. Reused for pll_locked here and for vga_rst_req in the pixel domain.

Test Plan (bench params RST_HOLD_CYC=4, LOCK_TIMEOUT_CYC=20, LOCK_STABLE_CYC=8, MAX_RETRIES=2):
1. Nominal lock: release rst_n; raise pll_locked 10 cycles after pll_rst falls and hold it -> pll_rst high exactly 4 cycles; STABILIZE entered 3 cycles after the lock edge; RUN 8 cycles later; pll_ok=1, vga_rst_req=0, retry_cnt=0.
2. Never lock: hold pll_locked=0 -> three RESET_PLL pulses of 4 cycles each, each followed by a 20-cycle WAIT_LOCK; retry_cnt steps 0,1,2; then FAIL with pll_fail=1, pll_rst=1. It remains in FAIL for 1000 cycles.
3. Glitchy lock: drop pll_locked for 3 cycles midway through STABILIZE -> returns to WAIT_LOCK; retry_cnt unchanged; RUN reached only after 8 clean cycles.
4. Lock loss in RUN: drop pll_locked for 1 cycle -> lock_loss_cnt=1, vga_rst_req=1 within 3 cycles, new 4-cycle pll_rst pulse. Repeat 300 times -> lock_loss_cnt saturates at 255.
5. Restart: pulse ctrl_restart in FAIL and again in RUN -> RESET_PLL next cycle, retry_cnt=0. Restart coinciding with a RUN lock loss -> RESET_PLL and lock_loss_cnt+1.
6. Async reset mid-WAIT_LOCK: assert rst_n between clock edges -> all outputs take reset values immediately, without waiting for an edge; after release the sequence restarts from a full 4-cycle pll_rst pulse.

Source files
------------

// File: rtl/vga_pkg.sv
// ============================================================================
// vga_pkg : shared state encoding and timing constants for the VGA clocking.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package vga_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_state_e;

    // Defaults sized for a 50 MHz reference clock
    localparam int PLL_RST_HOLD     = 16;
    localparam int PLL_LOCK_TIMEOUT = 50000;
    localparam int PLL_LOCK_STABLE  = 1024;

    localparam int unsigned VGA_PIX_HZ = 32'd108_000_000;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// sync_2ff : generic two-flop synchronizer, asynchronous active-low reset.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/vga_pll_ctrl.sv
// ============================================================================
// vga_pll_ctrl : PLL reset / lock-qualification sequencer on the reference clock.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module vga_pll_ctrl
    import vga_pkg::*;
#(
    parameter int RST_HOLD_CYC     = PLL_RST_HOLD,
    parameter int LOCK_TIMEOUT_CYC = PLL_LOCK_TIMEOUT,
    parameter int LOCK_STABLE_CYC  = PLL_LOCK_STABLE,
    parameter int MAX_RETRIES      = 3,
    parameter int CNT_W            = 16
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       ctrl_restart,
    output logic       pll_rst,
    output logic       vga_rst_req,
    output logic       pll_ok,
    output logic       pll_fail,
    output logic [2:0] state_o,
    output logic [1:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

    logic             lock_s;
    pll_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]       retry_q, retry_d;
    logic [7:0]       loss_q, loss_d, loss_sat;
    logic             pll_rst_q, pll_rst_d;
    logic             vga_rst_q, vga_rst_d;
    logic             ok_q, ok_d;
    logic             fail_q, fail_d;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk_i  (refclk),
        .rst_ni (rst_n),
        .d_i    (pll_locked),
        .q_o    (lock_s)
    );

    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign loss_sat = (loss_q == 8'hFF) ? loss_q : loss_q + 8'd1;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RESET_PLL;
            cnt_q     <= '0;
            retry_q   <= '0;
            loss_q    <= '0;
            pll_rst_q <= 1'b1;
            vga_rst_q <= 1'b1;
            ok_q      <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
            pll_rst_q <= pll_rst_d;
            vga_rst_q <= vga_rst_d;
            ok_q      <= ok_d;
            fail_q    <= fail_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        if (ctrl_restart) begin
            // A lock loss seen in the same cycle as a restart is still counted
            if (state_q == ST_RUN && !lock_s) begin
                loss_d = loss_sat;
            end
            state_d = ST_RESET_PLL;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                ST_RESET_PLL: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = ST_STABILIZE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        cnt_d = '0;
                        if (retry_q < RETRY_MAX) begin
                            retry_d = retry_q + 2'd1;
                            state_d = ST_RESET_PLL;
                        end else begin
                            state_d = ST_FAIL;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_STABILIZE: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        loss_d  = loss_sat;
                        state_d = ST_RESET_PLL;
                        cnt_d   = '0;
                        retry_d = '0;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_RESET_PLL;
                    cnt_d   = '0;
                end
            endcase
        end

        // Outputs decode from the next state so they align with the state register
        pll_rst_d = (state_d == ST_RESET_PLL) || (state_d == ST_FAIL);
        vga_rst_d = (state_d != ST_RUN);
        ok_d      = (state_d == ST_RUN);
        fail_d    = (state_d == ST_FAIL);
    end

    assign pll_rst       = pll_rst_q;
    assign vga_rst_req   = vga_rst_q;
    assign pll_ok        = ok_q;
    assign pll_fail      = fail_q;
    assign state_o       = state_q;
    assign retry_cnt     = retry_q;
    assign lock_loss_cnt = loss_q;

endmodule

`default_nettype wire
